// File: rtl/cpu_oci_trace_pkg.sv
// Shared constants and frame layout for the Nios II OCI trace packers.
// Used by the DCT packer and by the reusable one-entry output slot.
package cpu_oci_trace_pkg;

    localparam int DCT_BUF_W  = 30;
    localparam int DCT_CNT_W  = 4;
    localparam logic [DCT_CNT_W-1:0] DCT_MAX = 4'd15;

    localparam int TM_FRAME_W = 36;
    localparam logic [1:0] TM_TYPE_DCT = 2'b01;

    typedef struct packed {
        logic [1:0]           ftype;
        logic [DCT_CNT_W-1:0] count;
        logic [DCT_BUF_W-1:0] buffer;
    } dct_frame_t;

endpackage

// File: rtl/cpu_oci_dct_outreg.sv
// One-entry valid/ready output slot shared by the trace packers.
// Accepts a new entry whenever it is empty or being drained in the same cycle.
module cpu_oci_dct_outreg #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load_valid,
    input  logic [W-1:0] i_load_data,
    output logic         o_load_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_load_ready;

    assign w_load_ready = !r_valid || i_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load_valid && w_load_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_load_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_load_ready = w_load_ready;
    assign o_valid      = r_valid;
    assign o_data       = r_data;

endmodule

// File: rtl/cpu_oci_dct_packer.sv
// Direct-branch compressed-trace packer: 2-bit branch codes into a 30-bit buffer, framed to the trace FIFO.
// Optional saturating dropped-branch counter port enabled by defining DCT_DROP_CNT_EN.
module cpu_oci_dct_packer
    import cpu_oci_trace_pkg::*;
#(
    parameter logic [1:0] CODE_TAKEN  = 2'b10,
    parameter logic [1:0] CODE_NTAKEN = 2'b01
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  trace_en,
    input  logic                  br_valid,
    input  logic                  br_taken,
    input  logic                  flush,
    output logic [DCT_BUF_W-1:0]  dct_buffer,
    output logic [DCT_CNT_W-1:0]  dct_count,
    output logic                  frm_valid,
    output logic [TM_FRAME_W-1:0] frm_data,
    input  logic                  frm_ready,
    output logic                  dct_ovf
`ifdef DCT_DROP_CNT_EN
    ,
    output logic [7:0]            dct_drop_cnt
`endif
);

    logic [DCT_BUF_W-1:0] r_buf;
    logic [DCT_CNT_W-1:0] r_cnt;
    logic                 r_pend;
    logic                 r_ovf;
    logic                 r_en_q;

    logic                 w_br;
    logic                 w_blocked;
    logic                 w_accept;
    logic                 w_drop;
    logic [1:0]           w_code;
    logic [DCT_BUF_W-1:0] w_nbuf;
    logic [DCT_CNT_W-1:0] w_ncnt;
    logic                 w_sync;
    logic                 w_want;
    logic                 w_slot_rdy;
    logic                 w_load;
    logic                 w_en_rise;
    dct_frame_t           w_frame;

    // A count of 15 only survives a clock edge when its frame could not reach the slot.
    assign w_blocked = (r_cnt == DCT_MAX);
    assign w_br      = br_valid && trace_en;
    assign w_accept  = w_br && !w_blocked && !r_pend;
    assign w_drop    = w_br && (w_blocked || r_pend);
    assign w_code    = br_taken ? CODE_TAKEN : CODE_NTAKEN;
    assign w_nbuf    = w_accept ? {r_buf[DCT_BUF_W-3:0], w_code} : r_buf;
    assign w_ncnt    = w_accept ? (r_cnt + 4'd1) : r_cnt;
    assign w_sync    = flush || r_pend;
    assign w_want    = (w_ncnt == DCT_MAX) || (w_sync && (w_ncnt != '0));
    assign w_load    = w_want && w_slot_rdy;
    assign w_en_rise = trace_en && !r_en_q;

    assign w_frame = '{ftype: TM_TYPE_DCT, count: w_ncnt, buffer: w_nbuf};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf  <= '0;
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= trace_en;
            if (w_load) begin
                r_buf  <= '0;
                r_cnt  <= '0;
                r_pend <= 1'b0;
            end else begin
                r_buf  <= w_nbuf;
                r_cnt  <= w_ncnt;
                r_pend <= w_sync && (w_ncnt != '0);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_en_rise) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef DCT_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (w_en_rise) begin
            r_drop_cnt <= '0;
        end
    end

    assign dct_drop_cnt = r_drop_cnt;
`endif

    cpu_oci_dct_outreg #(
        .W (TM_FRAME_W)
    ) u_outreg (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load_valid (w_want),
        .i_load_data  (w_frame),
        .o_load_ready (w_slot_rdy),
        .o_valid      (frm_valid),
        .o_data       (frm_data),
        .i_ready      (frm_ready)
    );

    assign dct_buffer = r_buf;
    assign dct_count  = r_cnt;
    assign dct_ovf    = r_ovf;

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Self-checking bench for cpu_oci_dct_packer: queue-based reference model plus directed literal checks.
// Works with or without DCT_DROP_CNT_EN defined.
module tb_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trace_en = 1'b1;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic        flush = 1'b0;
    logic        frm_ready = 1'b1;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frm_valid;
    logic [35:0] frm_data;
    logic        dct_ovf;
`ifdef DCT_DROP_CNT_EN
    logic [7:0]  dct_drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    cpu_oci_dct_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trace_en   (trace_en),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .flush      (flush),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .frm_valid  (frm_valid),
        .frm_data   (frm_data),
        .frm_ready  (frm_ready),
        .dct_ovf    (dct_ovf)
`ifdef DCT_DROP_CNT_EN
        ,
        .dct_drop_cnt (dct_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: branch codes kept as a list, output slot as one stored frame.
    logic [1:0]  mQ[$];
    logic        mSlotFull = 1'b0;
    logic [35:0] mSlot = '0;
    logic        mPend = 1'b0;
    logic        mOvf = 1'b0;
    int          mDrops = 0;
    logic        mEnPrev = 1'b0;

    function automatic logic [29:0] packList();
        logic [29:0] b = '0;
        foreach (mQ[i]) b = {b[27:0], mQ[i]};
        return b;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mQ.delete();
            mSlotFull = 1'b0;
            mSlot = '0;
            mPend = 1'b0;
            mOvf = 1'b0;
            mDrops = 0;
            mEnPrev = 1'b0;
        end else begin
            bit slotFree;
            bit drained;
            bit want;
            drained  = mSlotFull && frm_ready;
            slotFree = !mSlotFull || frm_ready;
            if (trace_en && !mEnPrev) begin
                mOvf = 1'b0;
                mDrops = 0;
            end
            mEnPrev = trace_en;
            if (br_valid && trace_en) begin
                if (mQ.size() == 15 || mPend) begin
                    mOvf = 1'b1;
                    if (mDrops < 255) mDrops++;
                end else begin
                    mQ.push_back(br_taken ? 2'b10 : 2'b01);
                end
            end
            want = (mQ.size() == 15) || ((flush || mPend) && mQ.size() > 0);
            if (want && slotFree) begin
                mSlot = {2'b01, 4'(mQ.size()), packList()};
                mSlotFull = 1'b1;
                mQ.delete();
                mPend = 1'b0;
            end else begin
                if (drained) mSlotFull = 1'b0;
                if ((flush || mPend) && mQ.size() > 0) mPend = 1'b1;
            end
        end
    end

    // Frames actually accepted from the DUT, with the cycle on which each handshake happened.
    logic [35:0] frames[$];
    int          stamps[$];
    int          cycleCnt = 0;

    always @(posedge clk) begin
        cycleCnt++;
        if (reset_n && frm_valid && frm_ready) begin
            frames.push_back(frm_data);
            stamps.push_back(cycleCnt);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic t, input logic f);
        @(negedge clk);
        br_valid = v;
        br_taken = t;
        flush    = f;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [35:0] frameAt(input int i);
        if (i < frames.size()) return frames[i];
        return 36'hF_FFFF_FFFF;
    endfunction

    function automatic int stampAt(input int i);
        if (i < stamps.size()) return stamps[i];
        return -100;
    endfunction

    // Per-cycle comparison against the model, after outputs settle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput("count", 64'(dct_count), 64'(mQ.size()));
            checkOutput("buffer", 64'(dct_buffer), 64'(packList()));
            checkOutput("frm_valid", 64'(frm_valid), 64'(mSlotFull));
            if (mSlotFull) checkOutput("frm_data", 64'(frm_data), 64'(mSlot));
            checkOutput("ovf", 64'(dct_ovf), 64'(mOvf));
`ifdef DCT_DROP_CNT_EN
            checkOutput("drop_cnt", 64'(dct_drop_cnt), 64'(mDrops));
`endif
        end
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("rst_count", 64'(dct_count), 64'd0);
        checkOutput("rst_buffer", 64'(dct_buffer), 64'd0);
        checkOutput("rst_valid", 64'(frm_valid), 64'd0);
        checkOutput("rst_data", 64'(frm_data), 64'd0);
        checkOutput("rst_ovf", 64'(dct_ovf), 64'd0);
        reset_n = 1'b1;

        $display("[TB] T,N,T packing");
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(0, 0, 0);
        #1;
        checkOutput("tnt_count", 64'(dct_count), 64'd3);
        checkOutput("tnt_buffer", 64'(dct_buffer), 64'(30'b10_01_10));
        checkOutput("tnt_noframe", 64'(frm_valid), 64'd0);
        frames.delete(); stamps.delete();
        applyStimulus(0, 0, 1);
        idle(3);
        checkOutput("tnt_nframes", 64'(frames.size()), 64'd1);
        checkOutput("tnt_frame", 64'(frameAt(0)), 64'({2'b01, 4'd3, 30'b10_01_10}));

        $display("[TB] 15 taken branches");
        frames.delete(); stamps.delete();
        repeat (15) applyStimulus(1, 1, 0);
        applyStimulus(0, 0, 0);
        #1;
        checkOutput("full_cleared", 64'(dct_count), 64'd0);
        checkOutput("full_valid", 64'(frm_valid), 64'd1);
        idle(2);
        checkOutput("full_nframes", 64'(frames.size()), 64'd1);
        checkOutput("full_frame", 64'(frameAt(0)), 64'({2'b01, 4'hF, 30'h2AAAAAAA}));

        $display("[TB] flush with branch in same cycle");
        frames.delete(); stamps.delete();
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 1);
        idle(3);
        checkOutput("fl5_nframes", 64'(frames.size()), 64'd1);
        checkOutput("fl5_frame", 64'(frameAt(0)), 64'({2'b01, 4'd5, 30'b10_10_01_01_10}));
        checkOutput("fl5_count", 64'(dct_count), 64'd0);

        $display("[TB] backpressure and overflow");
        frames.delete(); stamps.delete();
        @(negedge clk) frm_ready = 1'b0;
        repeat (46) applyStimulus(1, 1, 0);
        applyStimulus(0, 0, 0);
        #1;
        checkOutput("bp_count", 64'(dct_count), 64'd15);
        checkOutput("bp_valid", 64'(frm_valid), 64'd1);
        checkOutput("bp_ovf", 64'(dct_ovf), 64'd1);
`ifdef DCT_DROP_CNT_EN
        checkOutput("bp_drops", 64'(dct_drop_cnt), 64'd16);
`endif
        @(negedge clk) frm_ready = 1'b1;
        idle(4);
        checkOutput("bp_nframes", 64'(frames.size()), 64'd2);
        checkOutput("bp_frame0", 64'(frameAt(0)), 64'({2'b01, 4'hF, 30'h2AAAAAAA}));
        checkOutput("bp_frame1", 64'(frameAt(1)), 64'({2'b01, 4'hF, 30'h2AAAAAAA}));
        checkOutput("bp_b2b", 64'(stampAt(1) - stampAt(0)), 64'd1);

        $display("[TB] flush with empty buffer");
        frames.delete(); stamps.delete();
        applyStimulus(0, 0, 1);
        idle(3);
        checkOutput("fl0_nframes", 64'(frames.size()), 64'd0);
        checkOutput("fl0_valid", 64'(frm_valid), 64'd0);

        $display("[TB] trace_en toggle clears overflow");
        @(negedge clk) trace_en = 1'b0;
        applyStimulus(1, 1, 0);
        applyStimulus(0, 0, 0);
        checkOutput("dis_count", 64'(dct_count), 64'd0);
        @(negedge clk) trace_en = 1'b1;
        idle(1);
        checkOutput("en_ovf_clr", 64'(dct_ovf), 64'd0);

        $display("[TB] flush while slot busy");
        frames.delete(); stamps.delete();
        @(negedge clk) frm_ready = 1'b0;
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 1);
        applyStimulus(1, 1, 0);
        applyStimulus(0, 0, 0);
        #1;
        checkOutput("pend_count", 64'(dct_count), 64'd2);
        checkOutput("pend_ovf", 64'(dct_ovf), 64'd1);
        checkOutput("pend_valid", 64'(frm_valid), 64'd1);
        @(negedge clk) frm_ready = 1'b1;
        idle(4);
        checkOutput("pend_nframes", 64'(frames.size()), 64'd2);
        checkOutput("pend_frameA", 64'(frameAt(0)), 64'({2'b01, 4'd2, 30'b10_01}));
        checkOutput("pend_frameB", 64'(frameAt(1)), 64'({2'b01, 4'd2, 30'b01_01}));
        checkOutput("pend_b2b", 64'(stampAt(1) - stampAt(0)), 64'd1);

        $display("[TB] reset while frame pending");
        @(negedge clk) frm_ready = 1'b0;
        applyStimulus(1, 1, 1);
        repeat (7) applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        #1;
        checkOutput("pre_rst_count", 64'(dct_count), 64'd7);
        checkOutput("pre_rst_valid", 64'(frm_valid), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_count", 64'(dct_count), 64'd0);
        checkOutput("mid_rst_buffer", 64'(dct_buffer), 64'd0);
        checkOutput("mid_rst_valid", 64'(frm_valid), 64'd0);
        checkOutput("mid_rst_data", 64'(frm_data), 64'd0);
        checkOutput("mid_rst_ovf", 64'(dct_ovf), 64'd0);
        idle(2);
        reset_n = 1'b1;
        frm_ready = 1'b1;
        idle(3);
        checkOutput("post_rst_valid", 64'(frm_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
